divider_param: RTL and testbench
================================

Name: divider_param

Overview:
- Parametrised, iterative radix-2 restoring divider. It is the next generation of the team's fixed 16-bit divider.
- Adds a configurable width, a per-operation signed/unsigned mode, a divide-by-zero flag and a signed-overflow flag.
- Uses a start/busy/done handshake with registered result outputs.
- Sits beside the ALU datapath and is reused by firmware-visible math blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 4..64.
- SIGNED_EN, 1, 1 = signed_mode port honoured; 0 = signed_mode ignored and all operations are unsigned.

Ports:
- clk  input  1  rising-edge clock
- reset_a  input  1  synchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operation; sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; results valid and held from this cycle
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  divisor was 0; valid with done, held until next start
- overflow  output  1  signed MIN / -1; valid with done, held until next start

Behaviour:
- Reset (reset_a = 0 at a clk edge):
  - State goes to IDLE.
  - busy, done, div_by_zero, overflow, quotient, remainder all clear to 0.
  - Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, CALC, FIX.
- IDLE + start = 1 at edge k:
  - Latch operands.
  - Signed operation (signed_mode && SIGNED_EN): store |dividend| and |divisor| as unsigned magnitudes. Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clear the partial remainder and the iteration counter (width clog2(WIDTH+1)); set busy.
  - If divisor == 0: go straight to FIX with the zero flag set. Otherwise go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If the partial remainder is >= the divisor magnitude, subtract it and shift in 1; otherwise shift in 0.
  - The partial remainder is WIDTH+1 bits internally to avoid carry loss.
  - After exactly WIDTH iterations go to FIX.
- FIX, one cycle:
  - Negate the quotient if q_neg. Negate the remainder if r_neg, so the remainder takes the dividend's sign (truncating division).
  - Register quotient and remainder; pulse done = 1; clear busy; return to IDLE.
- Latency: done is high in cycle k+WIDTH+1 (17 cycles for WIDTH = 16). Divide-by-zero: done in cycle k+1.
- Divide by zero:
  - quotient = all ones, remainder = dividend unmodified, div_by_zero = 1, overflow = 0.
  - Applies in both signed and unsigned mode.
- Signed MIN / -1:
  - The algorithm naturally yields quotient = MIN and remainder = 0.
  - overflow = 1; detected at the start edge.
- Handshake and timing:
  - start while busy is ignored. Operand inputs may change freely after the start edge.
  - start in the same cycle as done (FIX state) is ignored. A back-to-back start is accepted the cycle after done.
  - Outputs hold their last result until the next accepted start clears the flags. quotient and remainder update only in FIX.
- Unsigned mode: all values are unsigned; overflow is never set.

Decomposition:
- Shared package divider_pkg:
  - state enum {IDLE, CALC, FIX}.
  - Function abs_val(WIDTH) and a clog2 helper for the counter width.
- Sub-module div_step: combinational restoring step (partial remainder, dividend magnitude, divisor magnitude -> next partial remainder, next dividend magnitude with quotient bit). Instantiated once.
- Top module: FSM, counter, operand/result registers, sign fix-up.

Test Plan:
- Unsigned: WIDTH=16, dividend=100, divisor=7 -> done 17 cycles after start; quotient=14, remainder=2; flags 0; busy high for 16 cycles.
- Signed: dividend=0xFF9C (-100), divisor=7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2). Then 100 / 0xFFF9 (-7) -> quotient=0xFFF2, remainder=2.
- Divide by zero: dividend=0x1234, divisor=0 -> done 1 cycle after start; quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Signed overflow: 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0, overflow=1. Same operands unsigned -> quotient=0, remainder=0x8000, overflow=0.
- Handshake: second start pulsed mid-CALC with different operands -> ignored, first result unchanged. Start the cycle after done -> accepted, new result.
- Reset: reset_a=0 at cycle 5 of CALC -> all outputs 0, no done pulse. Next start gives a correct result. Also repeat 100 / 7 with WIDTH=32 -> done at cycle 33.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  // Bits needed to hold the value n-1; never less than one.
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Magnitude of a w-bit two's-complement value held in the low bits of v.
  function automatic logic [63:0] abs_val(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] m;
    logic [63:0] n;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    n = (~v + 64'd1) & m;
    return (((v >> (w - 1)) & 64'd1) != 64'd0) ? n : (v & m);
  endfunction

endpackage

// File: rtl/divider_param_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH:0]   diff;
  logic             ge;

  assign sh    = {rem_i, dvd_i[WIDTH-1]};
  assign ge    = (sh >= {2'b00, dsr_i});
  assign diff  = sh[WIDTH:0] - {1'b0, dsr_i};
  assign rem_o = ge ? diff : sh[WIDTH:0];
  assign dvd_o = {dvd_i[WIDTH-2:0], ge};

endmodule

// File: rtl/divider_param.sv
// Parametrised radix-2 restoring divider with signed mode,
// divide-by-zero and signed-overflow flags.
module divider_param
  import divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = clog2_f(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zpend_q, zpend_d;
  logic             opend_q, opend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             sgn;

  assign sgn = signed_mode & SIGNED_EN;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (prem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zpend_d = zpend_q;
    opend_d = opend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          prem_d  = '0;
          dsr_d   = divisor;
          if (divisor == '0) begin
            // Raw dividend parks in the magnitude register for the remainder.
            dvd_d   = dividend;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            zpend_d = 1'b1;
            opend_d = 1'b0;
            state_d = FIX;
          end else begin
            if (sgn) begin
              dvd_d = WIDTH'(abs_val(64'(dividend), WIDTH));
              dsr_d = WIDTH'(abs_val(64'(divisor), WIDTH));
            end else begin
              dvd_d = dividend;
            end
            qneg_d  = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = sgn & dividend[WIDTH-1];
            zpend_d = 1'b0;
            opend_d = sgn & (dividend == MIN) & (divisor == '1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (zpend_q) begin
          quo_d = '1;
          rem_d = dvd_q;
        end else begin
          quo_d = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          rem_d = rneg_q ? (~prem_q[WIDTH-1:0] + WIDTH'(1))
                         : prem_q[WIDTH-1:0];
        end
        dbz_d   = zpend_q;
        ovf_d   = opend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_a) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zpend_q <= 1'b0;
      opend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zpend_q <= zpend_d;
      opend_q <= opend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_param.sv
// Table-driven and scoreboard bench for divider_param (16 and 32 bit).
module tb_divider_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a;
  logic        start;
  logic        sm;
  logic [15:0] dvd;
  logic [15:0] dsr;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        dbz;
  logic        ovf;

  logic        start32;
  logic        sm32;
  logic [31:0] dvd32;
  logic [31:0] dsr32;
  logic        busy32;
  logic        done32;
  logic [31:0] q32;
  logic [31:0] r32;
  logic        dbz32;
  logic        ovf32;

  int checks = 0;
  int errors = 0;

  divider_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .signed_mode (sm),
    .dividend    (dvd),
    .divisor     (dsr),
    .busy        (busy),
    .done        (done),
    .quotient    (q),
    .remainder   (r),
    .div_by_zero (dbz),
    .overflow    (ovf)
  );

  divider_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start32),
    .signed_mode (sm32),
    .dividend    (dvd32),
    .divisor     (dsr32),
    .busy        (busy32),
    .done        (done32),
    .quotient    (q32),
    .remainder   (r32),
    .div_by_zero (dbz32),
    .overflow    (ovf32)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    exp_t e;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = a;
    sb = b;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 17;
    if (b == 16'h0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000;
      e.r = 16'h0;
      e.ovf = 1'b1;
    end else if (s) begin
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic s);
    @(negedge clk);
    dvd = a;
    dsr = b;
    sm = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dvd = $urandom;
    dsr = $urandom;
  endtask

  // Waits for done; optionally pulses a stray start after sample mid_n.
  task automatic wait_done(input string nm, input int mid_n,
                           input logic [15:0] ma, input logic [15:0] mb);
    int   n;
    bit   seen;
    bit   busy_ok;
    exp_t e;
    n = 0;
    seen = 0;
    busy_ok = 1;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) begin
        seen = 1;
      end else begin
        if (!busy) busy_ok = 0;
        if (n == mid_n) begin
          dvd = ma;
          dsr = mb;
          sm = 1'b0;
          start = 1'b1;
        end
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_lat"}, 64'(n), 64'(e.lat));
      chk({nm, "_q"}, 64'(q), 64'(e.q));
      chk({nm, "_r"}, 64'(r), 64'(e.r));
      chk({nm, "_dbz"}, 64'(dbz), 64'(e.dbz));
      chk({nm, "_ovf"}, 64'(ovf), 64'(e.ovf));
      chk({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    end
  endtask

  vec_t tbl[10];

  initial begin
    int   n;
    bit   seen;
    exp_t e;
    tbl[0] = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0};
    tbl[1] = '{16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    tbl[3] = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
    tbl[4] = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0};
    tbl[7] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tbl[8] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'h0002, 1'b1, 16'hC000, 16'h0000, 1'b0, 1'b0};

    reset_a = 1'b0;
    start = 1'b0;
    sm = 1'b0;
    dvd = '0;
    dsr = '0;
    start32 = 1'b0;
    sm32 = 1'b0;
    dvd32 = '0;
    dsr32 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_q32", 64'(q32), 64'd0);
    reset_a = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.q = tbl[i].q;
      e.r = tbl[i].r;
      e.dbz = tbl[i].dbz;
      e.ovf = tbl[i].ovf;
      e.lat = tbl[i].dbz ? 1 : 17;
      issue(tbl[i].a, tbl[i].b, tbl[i].s);
      sbq.push_back(e);
      wait_done($sformatf("vec%0d", i), -1, 16'h0, 16'h0);
      if (tbl[i].dbz) begin
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        chk($sformatf("vec%0d_dbz_hold", i), 64'(dbz), 64'd1);
        chk($sformatf("vec%0d_q_hold", i), 64'(q), 64'hFFFF);
      end
    end

    // Stray start mid-CALC must be ignored.
    issue(16'd1000, 16'd33, 1'b0);
    sbq.push_back(model(16'd1000, 16'd33, 1'b0));
    wait_done("mid_calc", 5, 16'd9, 16'd4);

    // Start right after done is accepted.
    issue(16'd5000, 16'd3, 1'b0);
    sbq.push_back(model(16'd5000, 16'd3, 1'b0));
    wait_done("b2b", -1, 16'h0, 16'h0);

    // Start in the FIX cycle must be ignored.
    issue(16'hFF00, 16'd16, 1'b1);
    sbq.push_back(model(16'hFF00, 16'd16, 1'b1));
    wait_done("in_fix", 16, 16'd9, 16'd4);
    repeat (2) @(posedge clk);
    #1;
    chk("in_fix_no_busy", 64'(busy), 64'd0);
    chk("in_fix_q_hold", 64'(q), 64'hFFF0);

    // Reset in the middle of CALC.
    issue(16'd100, 16'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset_a = 1'b0;
    @(posedge clk);
    #1;
    reset_a = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_q", 64'(q), 64'd0);
    chk("mid_rst_r", 64'(r), 64'd0);
    chk("mid_rst_dbz", 64'(dbz), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("mid_rst_no_done", 64'(seen), 64'd0);
    issue(16'd1000, 16'd33, 1'b0);
    sbq.push_back(model(16'd1000, 16'd33, 1'b0));
    wait_done("after_rst", -1, 16'h0, 16'h0);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      a = 16'($urandom);
      b = (i % 2 == 0) ? 16'($urandom_range(1, 50)) : 16'($urandom);
      s = (i % 3 != 0);
      issue(a, b, s);
      sbq.push_back(model(a, b, s));
      wait_done($sformatf("rnd%0d", i), -1, 16'h0, 16'h0);
    end

    // 32-bit instance, unsigned 100 / 7.
    @(negedge clk);
    dvd32 = 32'd100;
    dsr32 = 32'd7;
    sm32 = 1'b0;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (done32) seen = 1;
    end
    chk("w32_done_seen", 64'(seen), 64'd1);
    chk("w32_lat", 64'(n), 64'd33);
    chk("w32_q", 64'(q32), 64'd14);
    chk("w32_r", 64'(r32), 64'd2);
    chk("w32_flags", 64'({dbz32, ovf32}), 64'd0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
